// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one pipelined memory port and sequences
// the block fill: address issue, data write-back, tag write and pipeline stalls.
module cache_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data_in,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fill_sel,
    output logic              fill_wr_en,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic              fill_tag_wr,
    output logic              icache_stall,
    output logic              dcache_stall,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam int OFF_W = $clog2(2 * WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            issue_cnt_q <= {CNT_W{1'b0}};
            recv_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Next-state and output decode; D-cache wins ties because it holds the older instruction.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        mem_en      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        fill_wr_en  = 1'b0;
        fill_addr   = {ADDR_W{1'b0}};
        fill_tag_wr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dcache_miss) begin
                    sel_d       = 1'b1;
                    base_d      = dcache_miss_addr & BASE_MASK;
                    issue_cnt_d = {CNT_W{1'b0}};
                    recv_cnt_d  = {CNT_W{1'b0}};
                    state_d     = S_FILL;
                end else if (icache_miss) begin
                    sel_d       = 1'b0;
                    base_d      = icache_miss_addr & BASE_MASK;
                    issue_cnt_d = {CNT_W{1'b0}};
                    recv_cnt_d  = {CNT_W{1'b0}};
                    state_d     = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (issue_cnt_q < CNT_W'(WORDS)) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end else begin
                    mem_en = 1'b0;
                end
                if (mem_data_valid) begin
                    fill_wr_en = 1'b1;
                    fill_addr  = base_q + ADDR_W'({recv_cnt_q, 1'b0});
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == CNT_W'(WORDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    fill_wr_en = 1'b0;
                end
            end
            S_DONE: begin
                fill_tag_wr = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fill_sel     = sel_q;
    assign fill_data    = mem_data_in;
    assign busy         = (state_q != S_IDLE);
    assign icache_stall = icache_miss & ~((state_q == S_DONE) & ~sel_q);
    assign dcache_stall = dcache_miss & ~((state_q == S_DONE) & sel_q);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: 4-cycle memory model, cycle-level reference
// model compared every cycle, plus literal pins on event timing per scenario.
module tb_cache_fill_arbiter;

    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss;
    logic [15:0] icache_miss_addr, dcache_miss_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        mem_en, fill_sel, fill_wr_en, fill_tag_wr;
    logic        icache_stall, dcache_stall, busy;
    logic [15:0] mem_addr, fill_addr, fill_data;

    cache_fill_arbiter #(.ADDR_W(16), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
        .mem_en(mem_en), .mem_addr(mem_addr), .fill_sel(fill_sel),
        .fill_wr_en(fill_wr_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_tag_wr(fill_tag_wr), .icache_stall(icache_stall),
        .dcache_stall(dcache_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc - t0, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: a word issued in cycle c returns in cycle c+4 with data = addr ^ A5A5.
    bit          dl_v [4];
    logic [15:0] dl_a [4];
    bit          mv_auto = 1'b0;
    logic [15:0] md_auto = 16'h0000;
    bit          stray_v = 1'b0;
    logic [15:0] stray_d = 16'hDEAD;
    assign mem_data_valid = mv_auto | stray_v;
    assign mem_data_in    = stray_v ? stray_d : md_auto;

    always @(posedge clk) begin
        #1;
        mv_auto = dl_v[3];
        md_auto = dl_a[3] ^ 16'hA5A5;
        for (int k = 3; k > 0; k--) begin
            dl_v[k] = dl_v[k-1];
            dl_a[k] = dl_a[k-1];
        end
        dl_v[0] = 1'b0;
    end

    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            dl_v[0] = 1'b1;
            dl_a[0] = mem_addr;
        end
    end

    // Reference model: age counts cycles since grant, recv counts accepted words.
    bit m_busy = 1'b0, m_sel = 1'b0, m_done = 1'b0;
    int m_base = 0, m_age = 0, m_recv = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_sel <= 1'b0;
            m_age <= 0; m_recv <= 0;
        end else if (!m_busy) begin
            if (dcache_miss || icache_miss) begin
                m_sel  <= dcache_miss;
                m_base <= (dcache_miss ? int'(dcache_miss_addr) : int'(icache_miss_addr)) / 16 * 16;
                m_busy <= 1'b1; m_done <= 1'b0; m_age <= 1; m_recv <= 0;
            end
        end else if (m_done) begin
            m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (mem_data_valid) begin
                m_recv <= m_recv + 1;
                if (m_recv + 1 == WORDS) m_done <= 1'b1;
            end
        end
    end

    bit          iss_at [64], wr_at [64], tag_at [64], sel_at [64], ist_at [64], dst_at [64];
    logic [15:0] iss_addr_at [64], wr_addr_at [64];

    // Per-cycle compare against the model, then log events relative to t0.
    always @(negedge clk) begin
        bit e_iss, e_wr;
        int e_ia, e_wa, off;
        e_iss = m_busy && !m_done && m_age >= 1 && m_age <= WORDS;
        e_ia  = (m_base + 2 * (m_age - 1)) % 65536;
        e_wr  = m_busy && !m_done && (mem_data_valid === 1'b1);
        e_wa  = (m_base + 2 * m_recv) % 65536;
        chk("busy", busy, m_busy);
        chk("mem_en", mem_en, e_iss);
        if (e_iss) chk("mem_addr", mem_addr, e_ia);
        chk("fill_wr_en", fill_wr_en, e_wr);
        if (e_wr) begin
            chk("fill_addr", fill_addr, e_wa);
            chk("fill_data", fill_data, e_wa ^ 32'hA5A5);
        end
        chk("fill_tag_wr", fill_tag_wr, m_done);
        if (m_busy) chk("fill_sel", fill_sel, m_sel);
        chk("icache_stall", icache_stall, icache_miss && !(m_done && !m_sel));
        chk("dcache_stall", dcache_stall, dcache_miss && !(m_done && m_sel));
        off = cyc - t0;
        if (off >= 0 && off < 64) begin
            iss_at[off] = mem_en;      iss_addr_at[off] = mem_addr;
            wr_at[off]  = fill_wr_en;  wr_addr_at[off]  = fill_addr;
            tag_at[off] = fill_tag_wr; sel_at[off]      = fill_sel;
            ist_at[off] = icache_stall; dst_at[off]     = dcache_stall;
        end
    end

    task automatic next(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start();
        t0 = cyc;
        for (int k = 0; k < 64; k++) begin
            iss_at[k] = 1'b0; wr_at[k] = 1'b0; tag_at[k] = 1'b0;
            sel_at[k] = 1'b0; ist_at[k] = 1'b0; dst_at[k] = 1'b0;
            iss_addr_at[k] = 16'h0000; wr_addr_at[k] = 16'h0000;
        end
    endtask

    function automatic int count_wr(input int lo, input int hi);
        int s = 0;
        for (int k = lo; k <= hi; k++) s += int'(wr_at[k]);
        return s;
    endfunction

    function automatic int count_tag(input int lo, input int hi);
        int s = 0;
        for (int k = lo; k <= hi; k++) s += int'(tag_at[k]);
        return s;
    endfunction

    initial begin
        rst = 1'b1;
        icache_miss = 1'b0; dcache_miss = 1'b0;
        icache_miss_addr = 16'h0000; dcache_miss_addr = 16'h0000;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_tag", fill_tag_wr, 1'b0);
        chk("rst_sel", fill_sel, 1'b0);
        icache_miss = 1'b1;
        #1;
        chk("rst_istall_follow", icache_stall, 1'b1);
        icache_miss = 1'b0;
        next(2);
        rst = 1'b0;
        next(1);

        // I miss alone
        start();
        icache_miss = 1'b1; icache_miss_addr = 16'h1236;
        next(14);
        icache_miss = 1'b0;
        chk("t1_iss1", iss_at[1], 1'b1);
        chk("t1_addr1", iss_addr_at[1], 16'h1230);
        chk("t1_addr8", iss_addr_at[8], 16'h123E);
        chk("t1_iss9", iss_at[9], 1'b0);
        chk("t1_wr4", wr_at[4], 1'b0);
        chk("t1_wrcnt", count_wr(5, 12), 8);
        chk("t1_tag13", tag_at[13], 1'b1);
        chk("t1_tagcnt", count_tag(0, 13), 1);
        chk("t1_ist12", ist_at[12], 1'b1);
        chk("t1_ist13", ist_at[13], 1'b0);
        chk("t1_sel", sel_at[5], 1'b0);
        next(2);

        // Simultaneous misses: D first, then I back-to-back
        start();
        icache_miss = 1'b1; icache_miss_addr = 16'h0040;
        dcache_miss = 1'b1; dcache_miss_addr = 16'h8008;
        next(14);
        dcache_miss = 1'b0;
        next(14);
        icache_miss = 1'b0;
        chk("t2_daddr1", iss_addr_at[1], 16'h8000);
        chk("t2_dsel", sel_at[1], 1'b1);
        chk("t2_dtag", tag_at[13], 1'b1);
        chk("t2_ist13", ist_at[13], 1'b1);
        chk("t2_iss14", iss_at[14], 1'b0);
        chk("t2_iaddr15", iss_addr_at[15], 16'h0040);
        chk("t2_isel", sel_at[15], 1'b0);
        chk("t2_itag", tag_at[27], 1'b1);
        chk("t2_ist26", ist_at[26], 1'b1);
        chk("t2_ist27", ist_at[27], 1'b0);
        next(2);

        // D miss during an I fill: no preemption
        start();
        icache_miss = 1'b1; icache_miss_addr = 16'h2000;
        next(3);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h3456;
        next(11);
        icache_miss = 1'b0;
        next(14);
        dcache_miss = 1'b0;
        chk("t3_sel5", sel_at[5], 1'b0);
        chk("t3_itag", tag_at[13], 1'b1);
        chk("t3_dst13", dst_at[13], 1'b1);
        chk("t3_dsel15", sel_at[15], 1'b1);
        chk("t3_daddr15", iss_addr_at[15], 16'h3450);
        chk("t3_dst26", dst_at[26], 1'b1);
        chk("t3_dst27", dst_at[27], 1'b0);
        next(2);

        // Stray valid in IDLE, then a normal D fill
        start();
        stray_v = 1'b1;
        next(2);
        stray_v = 1'b0;
        chk("t4_stray", count_wr(0, 1), 0);
        start();
        dcache_miss = 1'b1; dcache_miss_addr = 16'h4F1E;
        next(14);
        dcache_miss = 1'b0;
        chk("t4_wrcnt", count_wr(0, 63), 8);
        chk("t4_wa5", wr_addr_at[5], 16'h4F10);
        chk("t4_wa12", wr_addr_at[12], 16'h4F1E);
        next(2);

        // Reset mid D fill
        start();
        dcache_miss = 1'b1; dcache_miss_addr = 16'hABCD;
        next(7);
        rst = 1'b1; dcache_miss = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_mem_en", mem_en, 1'b0);
        chk("t5_wr", fill_wr_en, 1'b0);
        next(1);
        rst = 1'b0;
        next(5);
        chk("t5_addr1", iss_addr_at[1], 16'hABC0);
        chk("t5_wr5", wr_at[5], 1'b1);
        chk("t5_late", count_wr(8, 12), 0);
        chk("t5_notag", count_tag(0, 12), 0);
        start();
        dcache_miss = 1'b1; dcache_miss_addr = 16'h0102;
        next(14);
        dcache_miss = 1'b0;
        chk("t5_raddr1", iss_addr_at[1], 16'h0100);
        chk("t5_rwa5", wr_addr_at[5], 16'h0100);
        chk("t5_rtag", tag_at[13], 1'b1);
        next(2);

        // Flush: I miss dropped at cycle 4, fill still completes
        start();
        icache_miss = 1'b1; icache_miss_addr = 16'h5550;
        next(4);
        icache_miss = 1'b0;
        next(12);
        chk("t6_ist3", ist_at[3], 1'b1);
        chk("t6_ist4", ist_at[4], 1'b0);
        chk("t6_wrcnt", count_wr(0, 15), 8);
        chk("t6_tag", tag_at[13], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
